proximity_alarm: RTL and testbench

Downstream consumer of the ultrasonic sensor driver's per-measurement distance result. It accepts one 8-bit centimetre sample per measurement strobe and keeps a 4-sample moving average. It applies a hysteretic near/far decision and drives an active buzzer whose beep gap shrinks as the averaged distance falls. It also flags the sensor as stale when no valid sample arrives within a timeout.

---
 rtl/proximity_alarm.sv | 154 +++++++++++++++
 tb/tb_proximity_alarm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/proximity_alarm.sv
// rtl/proximity_alarm.sv - moving-average distance filter with hysteretic near flag, beeping buzzer and stale detect
module proximity_alarm #(
  parameter int AVG_LOG2         = 2,
  parameter int NEAR_CM          = 20,
  parameter int FAR_CM           = 30,
  parameter int BEEP_ON_CYCLES   = 2_500_000,
  parameter int BEEP_UNIT_CYCLES = 250_000,
  parameter int STALE_CYCLES     = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] distance,
  output logic [7:0] avg_distance,
  output logic       avg_valid,
  output logic       near,
  output logic       buzzer,
  output logic       stale
);

  localparam int                WIN       = 1 << AVG_LOG2;
  localparam int                SW        = 8 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(WIN);
  localparam logic [25:0]       ON_LAST   = 26'(BEEP_ON_CYCLES - 1);
  localparam logic [25:0]       UNIT      = 26'(BEEP_UNIT_CYCLES);
  localparam logic [25:0]       STALE_HIT = 26'(STALE_CYCLES - 1);
  localparam logic [25:0]       STALE_MAX = 26'(STALE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  logic [7:0]        win [WIN];
  logic [SW-1:0]     sum;
  logic [SW-1:0]     sum_next;
  logic [AVG_LOG2:0] fill;
  logic [AVG_LOG2:0] fill_next;
  logic [25:0]       stale_cnt;
  logic              accept;
  logic              timeout;

  state_t      state, state_next;
  logic [25:0] timer, timer_next;
  logic [25:0] gap, gap_next;
  logic [25:0] gap_calc;

  // 8'hFF is the sensor's no-echo code and never counts as a measurement;
  // an accepted sample in the timeout cycle pre-empts the timeout.
  assign accept    = sample_valid && (distance != 8'hFF);
  assign timeout   = !accept && (stale_cnt == STALE_HIT);
  assign sum_next  = sum + SW'(distance) - SW'(win[WIN-1]);
  assign fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
  assign gap_calc  = 26'(avg_distance) * UNIT;

  // Sample window, running sum and averaged output; timeout empties the window.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      sum          <= '0;
      fill         <= '0;
      avg_distance <= '0;
      avg_valid    <= 1'b0;
    end else if (timeout) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
      sum       <= '0;
      fill      <= '0;
      avg_valid <= 1'b0;
    end else if (accept) begin
      for (int i = WIN - 1; i > 0; i--) win[i] <= win[i-1];
      win[0] <= distance;
      sum    <= sum_next;
      fill   <= fill_next;
      if (fill_next == FILL_FULL) begin
        avg_distance <= 8'(sum_next >> AVG_LOG2);
        avg_valid    <= 1'b1;
      end else begin
        avg_valid <= 1'b0;
      end
    end else begin
      avg_valid <= 1'b0;
    end
  end

  // Hysteretic proximity decision, re-evaluated on each fresh average.
  always_ff @(posedge CLOCK_50) begin
    if (reset || timeout) begin
      near <= 1'b0;
    end else if (avg_valid) begin
      if (int'(avg_distance) <= NEAR_CM)     near <= 1'b1;
      else if (int'(avg_distance) >= FAR_CM) near <= 1'b0;
    end
  end

  // Silence counter; it parks one past the threshold so stale fires once and holds.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (accept) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else begin
      if (stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + 26'd1;
      if (timeout) stale <= 1'b1;
    end
  end

  // Buzzer FSM state, phase timer and latched gap length.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      gap   <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      gap   <= gap_next;
    end
  end

  // Beep sequencing: fixed on-time, gap scaled by distance, zero gap means continuous tone.
  always_comb begin
    state_next = state;
    timer_next = timer + 26'd1;
    gap_next   = gap;
    buzzer     = 1'b0;
    case (state)
      S_IDLE: begin
        timer_next = '0;
        if (near) state_next = S_ON;
      end
      S_ON: begin
        buzzer = 1'b1;
        if (timer == ON_LAST) begin
          timer_next = '0;
          if (gap_calc != 26'd0) begin
            state_next = S_OFF;
            gap_next   = gap_calc;
          end
        end
      end
      S_OFF: begin
        if (timer == gap - 26'd1) begin
          timer_next = '0;
          state_next = S_ON;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (!near || timeout) begin
      state_next = S_IDLE;
      timer_next = '0;
    end
  end

endmodule

// File: tb/tb_proximity_alarm.sv
// tb/tb_proximity_alarm.sv - scoreboard bench for proximity_alarm with short sim timing
module tb_proximity_alarm;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] distance = 8'd0;
  logic [7:0] avg_distance;
  logic       avg_valid;
  logic       near;
  logic       buzzer;
  logic       stale;

  int n_checks = 0;
  int n_fail   = 0;
  int model_q[$];
  int exp_q[$];
  int mon_exp;

  proximity_alarm #(
    .AVG_LOG2(2), .NEAR_CM(20), .FAR_CM(30),
    .BEEP_ON_CYCLES(4), .BEEP_UNIT_CYCLES(2), .STALE_CYCLES(100)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid), .distance(distance),
    .avg_distance(avg_distance), .avg_valid(avg_valid), .near(near), .buzzer(buzzer), .stale(stale)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every avg_valid pulse must match the oldest pending model average.
  always @(negedge CLOCK_50) begin
    if (avg_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL avg_unexpected: got avg_valid=1 avg_distance=%0d, required no pulse", avg_distance);
      end else begin
        mon_exp = exp_q.pop_front();
        if (avg_distance !== 8'(mon_exp)) begin
          n_fail++;
          $display("FAIL avg_value: got %0d, required %0d", avg_distance, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_sample(input logic [7:0] d);
    int s;
    sample_valid = 1'b1;
    distance     = d;
    if (d != 8'hFF) begin
      model_q.push_front(int'(d));
      if (model_q.size() > 4) void'(model_q.pop_back());
      if (model_q.size() == 4) begin
        s = 0;
        foreach (model_q[i]) s += model_q[i];
        exp_q.push_back(s / 4);
      end
    end
    @(posedge CLOCK_50);
    #1;
    sample_valid = 1'b0;
    distance     = 8'd0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (avg_distance !== 8'd0) begin n_fail++; $display("FAIL reset_avg: got %0d, required 0", avg_distance); end
    n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid: got %b, required 0", avg_valid); end
    n_checks++; if (near !== 1'b0) begin n_fail++; $display("FAIL reset_near: got %b, required 0", near); end
    n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b, required 0", buzzer); end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL reset_stale: got %b, required 0", stale); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_average();
    drive_sample(8'd10);
    drive_sample(8'd20);
    drive_sample(8'd30);
    drive_sample(8'd40);
    n_checks++; if (avg_valid !== 1'b1 || avg_distance !== 8'd25) begin n_fail++; $display("FAIL fill_first_avg: got valid=%b avg=%0d, required valid=1 avg=25", avg_valid, avg_distance); end
    drive_sample(8'd50);
    n_checks++; if (avg_distance !== 8'd35) begin n_fail++; $display("FAIL fill_slide_avg: got %0d, required 35", avg_distance); end
    tick();
    n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL fill_pulse_width: got avg_valid=%b, required 0", avg_valid); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_pending: got %0d outstanding averages, required 0", exp_q.size()); end
  endtask

  task automatic test_hysteresis();
    int hold_bad;
    repeat (4) drive_sample(8'd15);
    n_checks++; if (near !== 1'b0) begin n_fail++; $display("FAIL hyst_near_t1: got %b, required 0", near); end
    tick();
    n_checks++; if (near !== 1'b1) begin n_fail++; $display("FAIL hyst_near_t2: got %b, required 1", near); end
    hold_bad = 0;
    repeat (4) begin
      drive_sample(8'd25);
      tick();
      if (near !== 1'b1) hold_bad++;
    end
    n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL hyst_hold: got near low in %0d of 4 samples, required 0", hold_bad); end
    drive_sample(8'd32);
    drive_sample(8'd32);
    drive_sample(8'd32);
    n_checks++; if (near !== 1'b1) begin n_fail++; $display("FAIL hyst_far_t1: got %b, required 1", near); end
    tick();
    n_checks++; if (near !== 1'b0) begin n_fail++; $display("FAIL hyst_far_t2: got %b, required 0", near); end
    tick();
    hold_bad = 0;
    repeat (8) begin
      if (buzzer !== 1'b0) hold_bad++;
      tick();
    end
    n_checks++; if (hold_bad != 0) begin n_fail++; $display("FAIL hyst_buzzer_off: got buzzer high in %0d of 8 cycles, required 0", hold_bad); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hyst_pending: got %0d outstanding averages, required 0", exp_q.size()); end
  endtask

  task automatic test_beep_cadence();
    int waited, hi, lo, run;
    repeat (4) drive_sample(8'd10);
    waited = 0;
    while (buzzer !== 1'b1 && waited < 40) begin tick(); waited++; end
    n_checks++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL beep_start: got buzzer=%b after %0d cycles, required 1", buzzer, waited); end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      while (buzzer === 1'b1 && hi < 50) begin tick(); hi++; end
      lo = 0;
      while (buzzer === 1'b0 && lo < 50) begin tick(); lo++; end
      n_checks++; if (hi != 4) begin n_fail++; $display("FAIL beep_on_len[%0d]: got %0d cycles, required 4", p, hi); end
      n_checks++; if (lo != 20) begin n_fail++; $display("FAIL beep_gap_len[%0d]: got %0d cycles, required 20", p, lo); end
    end
    repeat (4) drive_sample(8'd0);
    repeat (20) tick();
    run = 0;
    repeat (30) begin
      if (buzzer === 1'b1) run++;
      tick();
    end
    n_checks++; if (run != 30) begin n_fail++; $display("FAIL beep_continuous: got buzzer high %0d of 30 cycles, required 30", run); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL beep_pending: got %0d outstanding averages, required 0", exp_q.size()); end
  endtask

  task automatic test_invalid_samples();
    repeat (4) drive_sample(8'd12);
    drive_sample(8'hFF);
    drive_sample(8'hFF);
    drive_sample(8'hFF);
    n_checks++; if (avg_distance !== 8'd12) begin n_fail++; $display("FAIL invalid_avg_hold: got %0d, required 12", avg_distance); end
    n_checks++; if (near !== 1'b1) begin n_fail++; $display("FAIL invalid_near_before: got %b, required 1", near); end
    repeat (96) tick();
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_early: got %b in idle cycle 100, required 0", stale); end
    tick();
    n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_set: got %b, required 1", stale); end
    n_checks++; if (near !== 1'b0) begin n_fail++; $display("FAIL stale_near: got %b, required 0", near); end
    n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL stale_buzzer: got %b, required 0", buzzer); end
    model_q.delete();
    drive_sample(8'd40);
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear: got %b, required 0", stale); end
    n_checks++; if (avg_distance !== 8'd12) begin n_fail++; $display("FAIL stale_refill_avg: got %0d, required 12", avg_distance); end
    drive_sample(8'd40);
    drive_sample(8'd40);
    drive_sample(8'd40);
    n_checks++; if (avg_valid !== 1'b1 || avg_distance !== 8'd40) begin n_fail++; $display("FAIL stale_refill_full: got valid=%b avg=%0d, required valid=1 avg=40", avg_valid, avg_distance); end
  endtask

  task automatic test_simultaneous();
    int bad;
    repeat (99) tick();
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL simul_before: got %b, required 0", stale); end
    drive_sample(8'd40);
    bad = 0;
    repeat (20) begin
      if (stale !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL simul_stale: got stale high in %0d of 20 cycles, required 0", bad); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_pending: got %0d outstanding averages, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_gap();
    int waited, bad;
    repeat (4) drive_sample(8'd15);
    waited = 0;
    while (buzzer !== 1'b1 && waited < 20) begin tick(); waited++; end
    while (buzzer !== 1'b0 && waited < 40) begin tick(); waited++; end
    repeat (5) tick();
    n_checks++; if (buzzer !== 1'b0 || near !== 1'b1) begin n_fail++; $display("FAIL gap_setup: got buzzer=%b near=%b, required buzzer=0 near=1", buzzer, near); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_q.delete();
    n_checks++; if (avg_distance !== 8'd0 || avg_valid !== 1'b0 || near !== 1'b0 || buzzer !== 1'b0 || stale !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_reset_outputs: got avg=%0d valid=%b near=%b buzzer=%b stale=%b, required all 0", avg_distance, avg_valid, near, buzzer, stale);
    end
    bad = 0;
    repeat (6) begin
      if (buzzer !== 1'b0 || near !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL gap_idle_after_reset: got activity in %0d of 6 cycles, required 0", bad); end
    repeat (3) drive_sample(8'd15);
    tick();
    n_checks++; if (near !== 1'b0) begin n_fail++; $display("FAIL refill_partial_near: got %b, required 0", near); end
    drive_sample(8'd15);
    n_checks++; if (near !== 1'b0 || buzzer !== 1'b0) begin n_fail++; $display("FAIL refill_t1: got near=%b buzzer=%b, required 0 0", near, buzzer); end
    tick();
    n_checks++; if (near !== 1'b1 || buzzer !== 1'b0) begin n_fail++; $display("FAIL refill_t2: got near=%b buzzer=%b, required 1 0", near, buzzer); end
    tick();
    n_checks++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL refill_t3_buzzer: got %b, required 1", buzzer); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL refill_pending: got %0d outstanding averages, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fill_average();
    test_hysteresis();
    test_beep_cadence();
    test_invalid_samples();
    test_simultaneous();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
